// File: rtl/wb_ram.sv
// Pipelined Wishbone B4 slave RAM with byte-lane writes, programmable wait states,
// stall back-pressure, out-of-range error termination and cycle-abort handling.
module wb_ram #(
  parameter int SIZE        = 'h400,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_adr,
  input  logic [DW/8-1:0] wb_sel,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack,
  output logic            wb_err,
  output logic            wb_stall
);

  localparam int NB    = DW / 8;
  localparam int LB    = $clog2(NB);
  localparam int ABITS = $clog2(SIZE);
  localparam int IW    = (ABITS > LB) ? ABITS - LB : 1;
  localparam int WORDS = SIZE / NB;
  localparam logic [AW:0] SIZE_A = (AW+1)'(SIZE);
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_d;
  logic [3:0]     cnt, cnt_d;
  logic           accept, in_range, latch, exec;
  logic [IW-1:0]  adr_idx;

  logic [IW-1:0]  idx_q;
  logic           we_q, rng_q;
  logic [NB-1:0]  sel_q;
  logic [DW-1:0]  dat_q;

  logic [IW-1:0]  x_idx;
  logic           x_we, x_rng;
  logic [NB-1:0]  x_sel;
  logic [DW-1:0]  x_dat;

  logic [DW-1:0]  mem [WORDS];
  logic [DW-1:0]  rd_q;
  logic           ack_q, err_q, rd_rsp_q;

  assign wb_stall = (state == BUSY);
  assign accept   = wb_cyc & wb_stb & ~wb_stall;
  assign in_range = {1'b0, wb_adr} < SIZE_A;
  assign adr_idx  = wb_adr[LB +: IW];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    latch   = 1'b0;
    exec    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            exec = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = BUSY;
            cnt_d   = WS;
          end
        end
      end
      BUSY: begin
        // dropping wb_cyc abandons the access before it touches memory
        if (!wb_cyc) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            exec    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // the live bus drives the access at zero wait states, the latched copy otherwise
  assign x_idx = (state == BUSY) ? idx_q : adr_idx;
  assign x_we  = (state == BUSY) ? we_q  : wb_we;
  assign x_rng = (state == BUSY) ? rng_q : in_range;
  assign x_sel = (state == BUSY) ? sel_q : wb_sel;
  assign x_dat = (state == BUSY) ? dat_q : wb_dat_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      rng_q    <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_rsp_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (latch) begin
        idx_q <= adr_idx;
        we_q  <= wb_we;
        rng_q <= in_range;
        sel_q <= wb_sel;
        dat_q <= wb_dat_i;
      end
      ack_q <= exec & x_rng;
      err_q <= exec & ~x_rng;
      if (exec) rd_rsp_q <= ~x_we;
    end
  end

  always_ff @(posedge clk) begin
    if (exec && x_rng) begin
      if (x_we) begin
        for (int i = 0; i < NB; i++) begin
          if (x_sel[i]) mem[x_idx][8*i +: 8] <= x_dat[8*i +: 8];
        end
      end else begin
        rd_q <= mem[x_idx];
      end
    end
  end

  assign wb_ack   = ack_q & wb_cyc;
  assign wb_err   = err_q & wb_cyc;
  assign wb_dat_o = (wb_ack && rd_rsp_q) ? rd_q : {DW{1'bx}};

endmodule
